// File: rtl/tight_acc_mm_ctrl.sv
// Command sequencer between the tight accelerator command/response port and an NxN matrix-multiply engine.
// Optional STATUS opcode (5) is compiled in when TIGHT_ACC_MM_CTRL_STATUS_EN is defined.
`timescale 1ns/1ps
module tight_acc_mm_ctrl #(
  parameter int N  = 10,
  parameter int DW = 64,
  parameter int AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_val,
  output logic          busy,
  input  logic [5:0]    cmd_opcode,
  input  logic [DW-1:0] cmd_config_data,
  output logic          resp_val,
  input  logic          resp_rdy,
  output logic [DW-1:0] resp_data,
  output logic          a_wr_en,
  output logic          b_wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          eng_start,
  input  logic          eng_done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [5:0] OP_MULT   = 6'd1;
  localparam logic [5:0] OP_FILLA  = 6'd2;
  localparam logic [5:0] OP_FILLB  = 6'd3;
  localparam logic [5:0] OP_READ   = 6'd4;
  localparam logic [5:0] OP_STATUS = 6'd5;

  localparam logic [AW-1:0] LAST_IDX = AW'(N*N-1);

  logic [2:0]    r_state;
  logic [AW-1:0] r_a_ptr, r_b_ptr, r_r_ptr;
  logic          r_a_full, r_b_full, r_res_valid;
  logic          r_stream;
  logic          r_resp_val, r_a_wr_en, r_b_wr_en, r_eng_start, r_rd_en;
  logic [DW-1:0] r_resp_data, r_wr_data;
  logic [AW-1:0] r_wr_addr, r_rd_addr;
  logic          w_accept;

  assign w_accept  = cmd_val && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign resp_val  = r_resp_val;
  assign resp_data = r_resp_data;
  assign a_wr_en   = r_a_wr_en;
  assign b_wr_en   = r_b_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign eng_start = r_eng_start;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;

  // Command decode, operand streaming, engine sequencing and response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a_ptr     <= '0;
      r_b_ptr     <= '0;
      r_r_ptr     <= '0;
      r_a_full    <= 1'b0;
      r_b_full    <= 1'b0;
      r_res_valid <= 1'b0;
      r_stream    <= 1'b0;
      r_resp_val  <= 1'b0;
      r_resp_data <= '0;
      r_a_wr_en   <= 1'b0;
      r_b_wr_en   <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_eng_start <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      r_a_wr_en   <= 1'b0;
      r_b_wr_en   <= 1'b0;
      r_eng_start <= 1'b0;
      r_rd_en     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (cmd_opcode)
              OP_FILLA: begin
                r_a_wr_en <= 1'b1;
                r_wr_addr <= r_a_ptr;
                r_wr_data <= cmd_config_data;
                if (r_a_ptr == LAST_IDX) begin
                  r_a_ptr  <= '0;
                  r_a_full <= 1'b1;
                end else begin
                  r_a_ptr <= r_a_ptr + AW'(1);
                end
              end
              OP_FILLB: begin
                r_b_wr_en <= 1'b1;
                r_wr_addr <= r_b_ptr;
                r_wr_data <= cmd_config_data;
                if (r_b_ptr == LAST_IDX) begin
                  r_b_ptr  <= '0;
                  r_b_full <= 1'b1;
                end else begin
                  r_b_ptr <= r_b_ptr + AW'(1);
                end
              end
              OP_MULT: begin
                if (r_a_full && r_b_full) begin
                  r_eng_start <= 1'b1;
                  r_res_valid <= 1'b0;
                  r_state     <= S_RUN;
                end else begin
                  r_resp_val  <= 1'b1;
                  r_resp_data <= '1;
                  r_state     <= S_RESP;
                end
              end
              OP_READ: begin
                if (r_res_valid) begin
                  r_r_ptr   <= '0;
                  r_stream  <= 1'b1;
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= '0;
                  r_state   <= S_RD_REQ;
                end else begin
                  r_resp_val  <= 1'b1;
                  r_resp_data <= '1;
                  r_state     <= S_RESP;
                end
              end
`ifdef TIGHT_ACC_MM_CTRL_STATUS_EN
              OP_STATUS: begin
                r_resp_val  <= 1'b1;
                r_resp_data <= DW'({8'(r_a_ptr), 8'(r_b_ptr), 5'b0, r_a_full, r_b_full, r_res_valid});
                r_state     <= S_RESP;
              end
`endif
              default: begin
              end
            endcase
          end
        end
        S_RUN: begin
          // The start cycle itself cannot signal completion; a level-style done is only honoured afterwards.
          if (!r_eng_start && eng_done) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b1;
            r_a_full    <= 1'b0;
            r_b_full    <= 1'b0;
            r_a_ptr     <= '0;
            r_b_ptr     <= '0;
          end
        end
        S_RD_REQ: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          r_resp_data <= rd_data;
          r_resp_val  <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (resp_rdy) begin
            r_resp_val <= 1'b0;
            if (r_stream && (r_r_ptr != LAST_IDX)) begin
              r_r_ptr   <= r_r_ptr + AW'(1);
              r_rd_en   <= 1'b1;
              r_rd_addr <= r_r_ptr + AW'(1);
              r_state   <= S_RD_REQ;
            end else begin
              if (r_stream) begin
                r_res_valid <= 1'b0;
              end
              r_stream <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tight_acc_mm_ctrl.sv
// Scoreboard bench for tight_acc_mm_ctrl: stimulus pushes expected writes, read addresses and responses,
// negedge monitors pop and compare. Covers STATUS when TIGHT_ACC_MM_CTRL_STATUS_EN is defined.
`timescale 1ns/1ps
module tb_tight_acc_mm_ctrl;
  localparam int N = 10;
  localparam int DW = 64;
  localparam int AW = 7;
  localparam logic [5:0] OP_MULT = 6'd1, OP_FILLA = 6'd2, OP_FILLB = 6'd3, OP_READ = 6'd4, OP_STATUS = 6'd5;
  localparam logic [63:0] ERR_WORD = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n, cmd_val, busy, resp_val, resp_rdy, a_wr_en, b_wr_en, eng_start, eng_done, rd_en;
  logic [5:0] cmd_opcode;
  logic [DW-1:0] cmd_config_data, resp_data, wr_data, rd_data;
  logic [AW-1:0] wr_addr, rd_addr;

  int n_pass = 0, n_total = 0, n_resp = 0, eng_start_cnt = 0;
  logic [63:0] resp_q[$];
  logic [71:0] wr_q[$];
  logic [AW-1:0] rda_q[$];

  tight_acc_mm_ctrl #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_val(cmd_val), .busy(busy), .cmd_opcode(cmd_opcode),
    .cmd_config_data(cmd_config_data), .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .a_wr_en(a_wr_en), .b_wr_en(b_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .eng_start(eng_start), .eng_done(eng_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] res_mem(input int idx);
    return 64'hC0DE_0000_0000_0000 | 64'(idx * 7 + 3);
  endfunction

  // Result buffer: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= res_mem(int'(rd_addr));

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (eng_start) eng_start_cnt++;
    if (resp_val && resp_rdy) begin
      n_resp++;
      if (resp_q.size() == 0) begin
        n_total++;
        $display("FAIL resp_unexpected: got %h expected no response", resp_data);
      end else check("resp_data", resp_data, resp_q.pop_front());
    end
    if (a_wr_en || b_wr_en) begin
      if (wr_q.size() == 0) begin
        n_total++;
        $display("FAIL wr_unexpected: got a=%b b=%b addr %0d expected no write", a_wr_en, b_wr_en, wr_addr);
      end else check("operand_write", {a_wr_en, b_wr_en, wr_addr, wr_data}, wr_q.pop_front());
    end
    if (rd_en) begin
      if (rda_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got rd_addr %0d expected no read", rd_addr);
      end else check("rd_addr", rd_addr, rda_q.pop_front());
    end
  end

  task automatic send(input logic [5:0] op, input logic [63:0] data);
    cmd_val = 1'b1; cmd_opcode = op; cmd_config_data = data;
    @(posedge clk); #1;
    cmd_val = 1'b0;
  endtask

  task automatic fill(input logic [5:0] op, input int base);
    for (int i = 0; i < N*N; i++) begin
      wr_q.push_back({(op == OP_FILLA), (op == OP_FILLB), AW'(i), 64'(base + i)});
      check("fill_busy", busy, 1'b0);
      cmd_val = 1'b1; cmd_opcode = op; cmd_config_data = 64'(base + i);
      @(posedge clk); #1;
    end
    cmd_val = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] held;
    int saved;
    cmd_val = 1'b0; cmd_opcode = 6'd0; cmd_config_data = 64'd0; resp_rdy = 1'b1; eng_done = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_strobes", {busy, resp_val, a_wr_en, b_wr_en, eng_start, rd_en}, 6'b0);
    check("reset_resp_data", resp_data, 64'd0);
    check("reset_addrs", {wr_addr, rd_addr}, 14'd0);
    check("reset_wr_data", wr_data, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: A fill streams one word per cycle
    fill(OP_FILLA, 0);
    // 2: MULT with only A complete is an error
    resp_q.push_back(ERR_WORD);
    send(OP_MULT, 64'd0);
    wait_idle(50, "mult_err_idle");
    check("mult_err_no_start", eng_start_cnt, 0);

    // 3: full MULT, done five cycles after start
    fill(OP_FILLB, 1000);
    send(OP_MULT, 64'd0);
    check("start_pulse", {eng_start, busy}, 2'b11);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      check("run_wait", {eng_start, busy}, 2'b01);
    end
    eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
    check("done_idle", busy, 1'b0);
    check("start_count", eng_start_cnt, 1);

    // 3/4: stream 100 result words, stalling word 7 for 10 cycles
    for (int i = 0; i < N*N; i++) begin
      resp_q.push_back(res_mem(i));
      rda_q.push_back(AW'(i));
    end
    send(OP_READ, 64'd0);
    for (int k = 0; k < 400; k++) begin
      if (rd_en && rd_addr == AW'(7)) break;
      @(posedge clk); #1;
    end
    check("reach_word7", {rd_en, rd_addr}, {1'b1, AW'(7)});
    resp_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (resp_val) break;
      @(posedge clk); #1;
    end
    check("word7_valid", resp_val, 1'b1);
    held = resp_data;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("stall_val_no_rd", {resp_val, rd_en}, 2'b10);
      check("stall_data", resp_data, held);
    end
    resp_rdy = 1'b1;
    wait_idle(600, "read_done_idle");
    check("read_words_left", resp_q.size(), 0);
    check("read_addrs_left", rda_q.size(), 0);
    resp_q.push_back(ERR_WORD);
    send(OP_READ, 64'd0);
    wait_idle(20, "reread_err_idle");

    send(6'd0, 64'd0);
    check("nop_idle", busy, 1'b0);

    // 5: reset while the engine is running
    fill(OP_FILLA, 2000);
    fill(OP_FILLB, 3000);
    send(OP_MULT, 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("midrun_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_strobes", {busy, resp_val, a_wr_en, b_wr_en, eng_start, rd_en}, 6'b0);
    check("midrun_reset_data", {resp_data, wr_addr, rd_addr}, 78'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    resp_q.push_back(ERR_WORD);
    send(OP_READ, 64'd0);
    wait_idle(20, "post_reset_read_idle");

`ifdef TIGHT_ACC_MM_CTRL_STATUS_EN
    // 6: STATUS after three A words
    for (int i = 0; i < 3; i++) begin
      wr_q.push_back({1'b1, 1'b0, AW'(i), 64'(50 + i)});
      send(OP_FILLA, 64'(50 + i));
    end
    resp_q.push_back(64'h0000_0000_0003_0000);
    send(OP_STATUS, 64'd0);
    wait_idle(20, "status_idle");
`else
    saved = n_resp;
    send(OP_STATUS, 64'd0);
    check("status_nop_busy", busy, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("status_nop_no_resp", n_resp, saved);
`endif

    repeat (5) begin @(posedge clk); #1; end
    check("resp_q_empty", resp_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("rda_q_empty", rda_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
